// File: rtl/uart_ahb_master_if.sv
// UART byte stream plus AHB-Lite master bus shared by uart_ahb_master and its neighbours.
interface uart_ahb_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;

  modport master (
    input  rx_data, rx_valid, tx_ready, HRDATA, HREADY,
    output tx_data, tx_valid, HADDR, HTRANS, HWRITE, HSIZE, HWDATA
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, HRDATA, HREADY,
    input  tx_data, tx_valid, HADDR, HTRANS, HWRITE, HSIZE, HWDATA
  );
endinterface

// File: rtl/uart_ahb_master.sv
// UART-framed (A3 write / A5 read) single-word AHB-Lite master; read data returned as 4 tx bytes LSB first.
// Bytes arriving during a bus transfer or tx response are dropped with rx_overrun; UART_MST_TIMEOUT_EN adds an inter-byte frame timeout.
module uart_ahb_master #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic             HCLK,
  input  logic             HRESET,
  uart_ahb_master_if.master bus,
  output logic             busy,
  output logic             rx_overrun
`ifdef UART_MST_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS_A, BUS_D, TX} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic        cmd_wr, cmd_wr_nxt;
  logic [31:0] addr, wdata, rdata;
  logic        abort;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      cmd_wr <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      cmd_wr <= cmd_wr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cmd_wr_nxt = cmd_wr;
    case (state)
      IDLE: begin
        if (bus.rx_valid && (bus.rx_data == 8'hA3 || bus.rx_data == 8'hA5)) begin
          state_nxt  = ADDR;
          cmd_wr_nxt = (bus.rx_data == 8'hA3);
          cnt_nxt    = 2'd0;
        end
      end
      ADDR: begin
        if (bus.rx_valid) begin
          cnt_nxt = cnt + 2'd1;
          if (cnt == 2'd3) begin
            state_nxt = cmd_wr ? WDATA : BUS_A;
            cnt_nxt   = 2'd0;
          end
        end
      end
      WDATA: begin
        if (bus.rx_valid) begin
          cnt_nxt = cnt + 2'd1;
          if (cnt == 2'd3) begin
            state_nxt = BUS_A;
            cnt_nxt   = 2'd0;
          end
        end
      end
      BUS_A: begin
        if (bus.HREADY) state_nxt = BUS_D;
      end
      BUS_D: begin
        if (bus.HREADY) begin
          state_nxt = cmd_wr ? IDLE : TX;
          cnt_nxt   = 2'd0;
        end
      end
      TX: begin
        if (bus.tx_ready) begin
          cnt_nxt = cnt + 2'd1;
          if (cnt == 2'd3) begin
            state_nxt = IDLE;
            cnt_nxt   = 2'd0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = 2'd0;
    end
  end

  // Frame fields are filled LSB byte first at the slot selected by cnt.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr  <= 32'd0;
      wdata <= 32'd0;
      rdata <= 32'd0;
    end else begin
      if (state == ADDR && bus.rx_valid)
        addr[{cnt, 3'b000} +: 8] <= bus.rx_data;
      if (state == WDATA && bus.rx_valid)
        wdata[{cnt, 3'b000} +: 8] <= bus.rx_data;
      if (state == BUS_D && bus.HREADY && !cmd_wr)
        rdata <= bus.HRDATA;
    end
  end

  assign bus.HADDR    = addr;
  assign bus.HWDATA   = wdata;
  assign bus.HSIZE    = 3'b010;
  assign bus.HTRANS   = (state == BUS_A) ? 2'b10 : 2'b00;
  assign bus.HWRITE   = (state == BUS_A) && cmd_wr;
  assign bus.tx_valid = (state == TX);
  assign bus.tx_data  = rdata[{cnt, 3'b000} +: 8];
  assign busy         = (state != IDLE);
  assign rx_overrun   = bus.rx_valid && (state == BUS_A || state == BUS_D || state == TX);

`ifdef UART_MST_TIMEOUT_EN
  logic [23:0] tmo_cnt;
  logic        in_frame;

  assign in_frame = (state == ADDR) || (state == WDATA);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)
      tmo_cnt <= 24'd0;
    else if (in_frame && !bus.rx_valid)
      tmo_cnt <= tmo_cnt + 24'd1;
    else
      tmo_cnt <= 24'd0;
  end

  assign abort   = in_frame && !bus.rx_valid && (tmo_cnt == TIMEOUT_CYCLES - 24'd1);
  assign timeout = abort;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_uart_ahb_master.sv
// Self-checking bench for uart_ahb_master: vector table, hand sequences and randomized frames vs a frame-level model.
module tb_uart_ahb_master;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  logic busy, rx_overrun;
`ifdef UART_MST_TIMEOUT_EN
  logic timeout;
`endif

  uart_ahb_master_if bus ();

  uart_ahb_master #(.TIMEOUT_CYCLES(24'd100)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .bus        (bus),
    .busy       (busy),
    .rx_overrun (rx_overrun)
`ifdef UART_MST_TIMEOUT_EN
    ,
    .timeout    (timeout)
`endif
  );

  initial forever #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          acyc;
    int          dcyc;
  } xfer_t;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] dat;
    int          hrm;
    int          txm;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    logic [31:0] exp_txseq;
    int          exp_acyc;
    int          exp_dcyc;
  } vec_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    hr_mode = 0;
  int    tx_mode = 0;
  int    ovr_cnt = 0;
  int    tmo_cnt = 0;
  xfer_t xq[$];
  logic [7:0] txq[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endtask

  // AHB slave side: drives HREADY per mode and logs completed transfers.
  initial begin : ahb_mon
    int          a_cyc, d_cyc, lowc;
    logic        in_d, busy_chk, c_wr;
    logic [31:0] c_addr, c_wd;
    xfer_t       r;
    a_cyc = 0; d_cyc = 0; lowc = 0; in_d = 0; busy_chk = 0; c_wr = 0;
    c_addr = 0; c_wd = 0;
    bus.HREADY = 1'b1;
    forever begin
      @(negedge HCLK);
      if (busy_chk) begin
        check("busy_low_after_write", busy, 0);
        busy_chk = 0;
      end
      if (HRESET) begin
        in_d = 0; a_cyc = 0; lowc = 0; bus.HREADY = 1'b1;
      end else begin
        case (hr_mode)
          1: bus.HREADY = ($urandom_range(0, 2) != 0);
          2: if ((in_d || bus.HTRANS == 2'b10) && lowc < 3) begin
               bus.HREADY = 1'b0; lowc++;
             end else bus.HREADY = 1'b1;
          default: bus.HREADY = 1'b1;
        endcase
        if (in_d) begin
          d_cyc++;
          if (d_cyc == 1) c_wd = bus.HWDATA;
          else if (c_wr) check("hwdata_stable", bus.HWDATA, c_wd);
          if (bus.HREADY) begin
            check("htrans_idle_dphase", {30'd0, bus.HTRANS}, 0);
            r = '{c_addr, c_wr, bus.HWDATA, a_cyc, d_cyc};
            xq.push_back(r);
            if (c_wr) busy_chk = 1;
            in_d = 0; a_cyc = 0; lowc = 0;
          end
        end else if (bus.HTRANS == 2'b10) begin
          a_cyc++;
          if (a_cyc == 1) begin
            c_addr = bus.HADDR; c_wr = bus.HWRITE;
          end else begin
            check("haddr_stable", bus.HADDR, c_addr);
            check("hwrite_stable", bus.HWRITE, c_wr);
          end
          if (bus.HREADY) begin
            check("hsize_word", {29'd0, bus.HSIZE}, 32'd2);
            in_d = 1; d_cyc = 0; lowc = 0;
          end
        end
      end
    end
  end

  // UART tx sink plus pulse counters.
  initial begin : tx_sink
    logic       held, tog;
    logic [7:0] hd;
    held = 0; tog = 0; hd = 0;
    bus.tx_ready = 1'b0;
    forever begin
      @(negedge HCLK);
      if (rx_overrun) ovr_cnt++;
`ifdef UART_MST_TIMEOUT_EN
      if (timeout) tmo_cnt++;
`endif
      if (HRESET) held = 0;
      if (held && bus.tx_valid) check("tx_data_hold", {24'd0, bus.tx_data}, {24'd0, hd});
      case (tx_mode)
        1: begin tog = ~tog; bus.tx_ready = tog; end
        2: bus.tx_ready = ($urandom_range(0, 1) == 1);
        3: bus.tx_ready = 1'b0;
        default: bus.tx_ready = 1'b1;
      endcase
      if (bus.tx_valid && !HRESET) begin
        if (bus.tx_ready) begin
          txq.push_back(bus.tx_data); held = 0;
        end else begin
          held = 1; hd = bus.tx_data;
        end
      end else held = 0;
    end
  end

  // Caller must be at posedge+1; returns at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge HCLK); #1;
    bus.rx_valid = 1'b0;
    repeat (gap) begin @(posedge HCLK); #1; end
  endtask

  task automatic send_frame(input logic rd, input logic [31:0] a, input logic [31:0] d, input int maxgap);
    logic [31:0] v;
    send_byte(rd ? 8'hA5 : 8'hA3, $urandom_range(0, maxgap));
    v = a;
    for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8], $urandom_range(0, maxgap));
    if (!rd) begin
      v = d;
      for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8], $urandom_range(0, maxgap));
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (busy && n < budget);
    check(name, busy, 0);
    @(posedge HCLK); #1;
  endtask

  vec_t        vt[5];
  xfer_t       x;
  logic [31:0] ra, rdt, rhr, v;
  logic        rrd;
  logic [7:0]  g;
  int          o0, n;

  initial begin : main
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.HRDATA   = 32'h0;

    vt[0] = '{1'b0, 32'h4C000000, 32'hA5A85501, 0, 0, 32'h4C000000, 32'hA5A85501, 32'h0, 1, 1};
    vt[1] = '{1'b1, 32'h4C000018, 32'h12345678, 0, 1, 32'h4C000018, 32'h0, 32'h78563412, 1, 1};
    vt[2] = '{1'b0, 32'h4C000010, 32'h00000001, 2, 0, 32'h4C000010, 32'h00000001, 32'h0, 4, 4};
    vt[3] = '{1'b1, 32'h4C000004, 32'hDEADBEEF, 2, 2, 32'h4C000004, 32'h0, 32'hEFBEADDE, 4, 4};
    vt[4] = '{1'b0, 32'hFFFFFFFC, 32'h80000000, 0, 1, 32'hFFFFFFFC, 32'h80000000, 32'h0, 1, 1};

    // Reset values
    repeat (3) @(negedge HCLK);
    check("rst_busy", busy, 0);
    check("rst_htrans", {30'd0, bus.HTRANS}, 0);
    check("rst_haddr", bus.HADDR, 0);
    check("rst_hwrite", bus.HWRITE, 0);
    check("rst_hwdata", bus.HWDATA, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 0);
    check("rst_rx_overrun", rx_overrun, 0);
    check("rst_hsize", {29'd0, bus.HSIZE}, 32'd2);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // Vector table
    foreach (vt[i]) begin
      xq.delete(); txq.delete();
      hr_mode = vt[i].hrm; tx_mode = vt[i].txm;
      bus.HRDATA = vt[i].rd ? vt[i].dat : 32'h0BAD0BAD;
      send_frame(vt[i].rd, vt[i].addr, vt[i].dat, 0);
      wait_idle("vec_done", 300);
      check("vec_nxfer", xq.size(), 1);
      if (xq.size() > 0) begin
        x = xq.pop_front();
        check("vec_haddr", x.addr, vt[i].exp_addr);
        check("vec_hwrite", x.wr, !vt[i].rd);
        check("vec_addr_cycles", x.acyc, vt[i].exp_acyc);
        check("vec_data_cycles", x.dcyc, vt[i].exp_dcyc);
        if (!vt[i].rd) check("vec_hwdata", x.wdata, vt[i].exp_wd);
      end
      check("vec_ntx", txq.size(), vt[i].rd ? 4 : 0);
      if (vt[i].rd) begin
        v = vt[i].exp_txseq;
        for (int k = 0; k < 4 && k < txq.size(); k++)
          check("vec_tx_byte", {24'd0, txq[k]}, {24'd0, v[31-8*k -: 8]});
      end
    end
    hr_mode = 0; tx_mode = 0;

    // Garbage in IDLE is ignored silently
    xq.delete(); o0 = ovr_cnt;
    send_byte(8'h55, 1);
    send_byte(8'hA4, 2);
    check("garbage_busy", busy, 0);
    check("garbage_overrun", ovr_cnt - o0, 0);
    check("garbage_nxfer", xq.size(), 0);

    // Overrun during TX with transmitter stalled
    xq.delete(); txq.delete();
    tx_mode = 3; bus.HRDATA = 32'hCAFEF00D;
    send_frame(1'b1, 32'h4C000008, 32'h0, 0);
    n = 0;
    while (!bus.tx_valid && n < 50) begin @(negedge HCLK); n++; end
    check("ovr_tx_valid_reached", bus.tx_valid, 1);
    @(posedge HCLK); #1;
    o0 = ovr_cnt;
    send_byte(8'hA3, 1);
    check("ovr_pulse_count", ovr_cnt - o0, 1);
    @(negedge HCLK);
    check("ovr_tx_byte0_held", {24'd0, bus.tx_data}, 32'h0D);
    check("ovr_still_busy", busy, 1);
    @(posedge HCLK); #1;
    tx_mode = 0;
    wait_idle("ovr_done", 100);
    check("ovr_ntx", txq.size(), 4);
    v = 32'h0DF0FECA;
    for (int k = 0; k < 4 && k < txq.size(); k++)
      check("ovr_tx_byte", {24'd0, txq[k]}, {24'd0, v[31-8*k -: 8]});
    check("ovr_nxfer", xq.size(), 1);

    // Reset mid-frame drops the partial frame
    xq.delete(); txq.delete();
    send_byte(8'hA3, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    HRESET = 1'b1;
    @(negedge HCLK);
    check("midrst_busy", busy, 0);
    check("midrst_haddr", bus.HADDR, 0);
    check("midrst_htrans", {30'd0, bus.HTRANS}, 0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    bus.HRDATA = 32'h0A0B0C0D;
    send_frame(1'b1, 32'h4C000018, 32'h0, 0);
    wait_idle("midrst_done", 100);
    check("midrst_nxfer", xq.size(), 1);
    if (xq.size() > 0) begin
      x = xq.pop_front();
      check("midrst_haddr_rd", x.addr, 32'h4C000018);
      check("midrst_hwrite", x.wr, 0);
    end
    check("midrst_ntx", txq.size(), 4);
    if (txq.size() == 4) check("midrst_tx_first", {24'd0, txq[0]}, 32'h0D);

`ifdef UART_MST_TIMEOUT_EN
    // Inter-byte timeout aborts a partial frame
    xq.delete(); o0 = tmo_cnt;
    send_byte(8'hA3, 0); send_byte(8'h00, 0);
    repeat (95) @(negedge HCLK);
    check("tmo_not_early", tmo_cnt - o0, 0);
    check("tmo_busy_before", busy, 1);
    repeat (10) @(negedge HCLK);
    check("tmo_pulse", tmo_cnt - o0, 1);
    check("tmo_busy_after", busy, 0);
    check("tmo_no_xfer", xq.size(), 0);
    @(posedge HCLK); #1;
    send_frame(1'b0, 32'h4C00000C, 32'h01020304, 0);
    wait_idle("tmo_next_done", 100);
    check("tmo_next_nxfer", xq.size(), 1);
    if (xq.size() > 0) begin
      x = xq.pop_front();
      check("tmo_next_haddr", x.addr, 32'h4C00000C);
      check("tmo_next_hwdata", x.wdata, 32'h01020304);
    end
`endif

    // Randomized frames against a frame-level model
    hr_mode = 1; tx_mode = 2; o0 = ovr_cnt;
    for (int f = 0; f < 30; f++) begin
      xq.delete(); txq.delete();
      rrd = $urandom_range(0, 1);
      ra = $urandom; rdt = $urandom; rhr = $urandom;
      bus.HRDATA = rhr;
      if ($urandom_range(0, 2) == 0) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA3 || g == 8'hA5) g = 8'h00;
        send_byte(g, $urandom_range(0, 2));
      end
      send_frame(rrd, ra, rdt, 2);
      wait_idle("rnd_done", 400);
      check("rnd_nxfer", xq.size(), 1);
      if (xq.size() > 0) begin
        x = xq.pop_front();
        check("rnd_haddr", x.addr, ra);
        check("rnd_hwrite", x.wr, !rrd);
        if (!rrd) check("rnd_hwdata", x.wdata, rdt);
      end
      check("rnd_ntx", txq.size(), rrd ? 4 : 0);
      if (rrd)
        for (int k = 0; k < 4 && k < txq.size(); k++)
          check("rnd_tx_byte", {24'd0, txq[k]}, (rhr >> (8 * k)) & 32'hFF);
    end
    check("rnd_no_overrun", ovr_cnt - o0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_ahb_master.md
Name: uart_ahb_master

Overview:
- Debug/firmware-load bus master between the UART receiver/transmitter pair (UART_MASTER_RX/TX pins) and the system AHB-Lite fabric.
- Consumes received bytes, parses write frames (0xA3) and read frames (0xA5), and issues single 32-bit AHB-Lite transfers.
- Read frames return data to the UART transmitter as bytes.
- Used by the host to drive the flash-writer registers at 0x4C000000–0x4C000018.

Parameters:
- TIMEOUT_CYCLES, 24'd1_000_000: inter-byte frame timeout in HCLK cycles. Used only when UART_MST_TIMEOUT_EN is defined.

Ports:
- HCLK  input  1  system clock
- HRESET  input  1  reset; asynchronous, active-high
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe: rx_data is valid
- tx_data  output  8  byte to transmit
- tx_valid  output  1  tx_data is valid; held until accepted
- tx_ready  input  1  transmitter accepts tx_data when tx_valid && tx_ready
- HADDR  output  32  AHB address
- HTRANS  output  2  AHB transfer type (IDLE=2'b00, NONSEQ=2'b10)
- HWRITE  output  1  AHB write
- HSIZE  output  3  always 3'b010 (word)
- HWDATA  output  32  AHB write data
- HRDATA  input  32  AHB read data
- HREADY  input  1  AHB ready
- busy  output  1  high in any state other than IDLE
- rx_overrun  output  1  one-cycle pulse: rx byte dropped while not accepting

Behaviour:
- Reset (async on HRESET high): state=IDLE, byte counter=0, HADDR=0, HTRANS=IDLE, HWRITE=0, HWDATA=0, tx_data=0, tx_valid=0, busy=0, rx_overrun=0. HSIZE is constant 3'b010.
- Frame formats:
  - Write: A3, A[7:0], A[15:8], A[23:16], A[31:24], D[7:0], D[15:8], D[23:16], D[31:24].
  - Read: A5, A[7:0]..A[31:24]. Response is 4 tx bytes, LSB first.
- States: IDLE, ADDR, WDATA, BUS_A, BUS_D, TX.
- IDLE:
  - rx_valid with 0xA3 -> ADDR, cmd=write.
  - rx_valid with 0xA5 -> ADDR, cmd=read.
  - Any other byte is silently discarded; stay in IDLE, no overrun pulse.
- ADDR: each rx_valid shifts the byte into the address register at position cnt (LSB first); cnt increments. On the 4th byte: write -> WDATA (cnt=0); read -> BUS_A.
- WDATA: same capture into the write-data register; after the 4th byte -> BUS_A.
- BUS_A:
  - HTRANS=NONSEQ, HADDR=captured address, HWRITE=cmd.
  - Hold until the cycle with HREADY=1 (address phase accepted), then -> BUS_D with HTRANS=IDLE, HWRITE=0.
- BUS_D:
  - Write: HWDATA driven with the captured data throughout.
  - On HREADY=1: write -> IDLE; read -> capture HRDATA, -> TX with cnt=0.
  - Minimum transfer: 1 address cycle + 1 data cycle. Each HREADY=0 cycle adds one cycle.
- TX:
  - tx_valid=1, tx_data=rdata byte cnt.
  - On tx_valid && tx_ready: cnt++. After the 4th handshake, tx_valid=0 -> IDLE.
  - tx_data must not change while tx_valid=1 and tx_ready=0.
- rx_valid in BUS_A, BUS_D or TX: byte dropped, rx_overrun pulses 1 cycle, state unaffected.
- An rx byte arriving on the same cycle a frame completes belongs to the next phase only if the state accepts bytes in the following cycle. Otherwise it is an overrun.
- Reset asserted mid-frame or mid-transfer: immediate return to the reset values above. A partially received frame is lost.
- Byte counter is 2 bits; it wraps only through explicit clears at state entry.

Optional Feature:
- Macro UART_MST_TIMEOUT_EN.
- Defined:
  - 24-bit counter clears on every accepted rx byte and increments in ADDR/WDATA.
  - Reaching TIMEOUT_CYCLES aborts the frame -> IDLE with no bus transfer.
  - Output timeout (1 bit) pulses one cycle on abort.
- Not defined: no counter and no timeout port. A partial frame waits indefinitely.

Test Plan:
- Write, zero wait: rx A3 00 00 00 4C 01 55 A8 A5 -> one NONSEQ write, HADDR=0x4C000000, HWDATA=0xA5A85501, HWRITE=1; busy drops the cycle after the data phase.
- Read with tx backpressure: rx A5 18 00 00 4C, HRDATA=0x12345678, tx_ready toggled 1/0 -> tx bytes 78,56,34,12 in order, each held stable while tx_ready=0.
- Wait states: write to 0x4C000010 data 0x00000001 with HREADY low 3 cycles in both address and data phases -> HADDR/HTRANS/HWDATA stable, exactly one transfer issued.
- Garbage and overrun: rx 0x55 in IDLE -> ignored, no bus activity; rx byte during TX state -> rx_overrun pulses once, response bytes unchanged.
- Reset mid-frame: rx A3 00 00, then HRESET pulse, then full read frame for 0x4C000018 -> only the read transfer occurs, with correct address.
- With UART_MST_TIMEOUT_EN (TIMEOUT_CYCLES=100): rx A3 00, idle 100 cycles -> timeout pulse, state IDLE. A following valid write frame completes normally.
